// File: rtl/lcd_bus_monitor.sv
// Receiving end of the 4-bit HD44780-style LCD write bus: reassembles nibbles,
// executes the driver's instruction subset and shadows a 2x16 display RAM.
module lcd_bus_monitor #(
  parameter int CLEAR_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] row0,
  output logic [127:0] row1,
  output logic [6:0]   ddram_addr,
  output logic         display_on,
  output logic         byte_valid,
  output logic [7:0]   byte_data,
  output logic         byte_rs,
  output logic         busy,
  output logic         err_overrun,
  output logic         err_read,
  output logic         err_addr
);

  typedef enum logic [1:0] {INIT, HI, LO, CLR} state_t;

  localparam logic [15:0] CLR_LAST = 16'(CLEAR_CYCLES - 1);

  state_t      state;
  logic [2:0]  e_sync;
  logic [1:0]  rs_sync;
  logic [1:0]  rw_sync;
  logic [3:0]  d_s1;
  logic [3:0]  d_s2;
  logic [3:0]  hi_nib;
  logic [15:0] clr_cnt;
  logic        strobe;
  logic        rs_now;
  logic        rw_now;
  logic [7:0]  full_byte;
  logic [4:0]  clr_cell;

  function automatic logic addr_valid(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    if (a == 7'h0F)      return 7'h40;
    else if (a == 7'h4F) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  // e_sync[2] is the edge-detect register behind the two synchronizer flops
  assign strobe    = e_sync[2] & ~e_sync[1];
  assign rs_now    = rs_sync[1];
  assign rw_now    = rw_sync[1];
  assign full_byte = {hi_nib, d_s2};
  assign clr_cell  = clr_cnt[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      e_sync  <= '0;
      rs_sync <= '0;
      rw_sync <= '0;
      d_s1    <= '0;
      d_s2    <= '0;
    end else begin
      e_sync  <= {e_sync[1:0], LCD_E};
      rs_sync <= {rs_sync[0], LCD_RS};
      rw_sync <= {rw_sync[0], LCD_RW};
      d_s1    <= LCD_D;
      d_s2    <= d_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      row0        <= {16{8'h20}};
      row1        <= {16{8'h20}};
      ddram_addr  <= '0;
      display_on  <= 1'b0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_rs     <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_read    <= 1'b0;
      err_addr    <= 1'b0;
      hi_nib      <= '0;
      clr_cnt     <= '0;
    end else begin
      byte_valid <= 1'b0;

      // Clear fill: one cell per cycle, row0 char 0 first; cycles past cell 31 only pad busy
      if (state == CLR) begin
        if (clr_cnt < 16'd32) begin
          if (!clr_cell[4]) row0[{~clr_cell[3:0], 3'b000} +: 8] <= 8'h20;
          else              row1[{~clr_cell[3:0], 3'b000} +: 8] <= 8'h20;
        end
        if (clr_cnt == CLR_LAST) begin
          busy       <= 1'b0;
          ddram_addr <= '0;
          state      <= HI;
        end else begin
          clr_cnt <= clr_cnt + 16'd1;
        end
      end

      // busy is still high on the last CLR cycle, so a coinciding strobe is an overrun
      if (strobe) begin
        if (rw_now) begin
          err_read <= 1'b1;
        end else if (busy) begin
          err_overrun <= 1'b1;
        end else begin
          case (state)
            INIT: if (d_s2 == 4'h2) state <= HI;
            HI: begin
              hi_nib <= d_s2;
              state  <= LO;
            end
            LO: begin
              byte_valid <= 1'b1;
              byte_data  <= full_byte;
              byte_rs    <= rs_now;
              state      <= HI;
              if (rs_now) begin
                if (addr_valid(ddram_addr)) begin
                  if (!ddram_addr[6]) row0[{~ddram_addr[3:0], 3'b000} +: 8] <= full_byte;
                  else                row1[{~ddram_addr[3:0], 3'b000} +: 8] <= full_byte;
                end
                ddram_addr <= next_addr(ddram_addr);
              end else if (full_byte == 8'h01) begin
                state   <= CLR;
                busy    <= 1'b1;
                clr_cnt <= '0;
              end else if (full_byte[7:1] == 7'b0000001) begin
                ddram_addr <= '0;
              end else if (full_byte[7:3] == 5'b00001) begin
                display_on <= full_byte[2];
              end else if (full_byte[7]) begin
                if (addr_valid(full_byte[6:0])) ddram_addr <= full_byte[6:0];
                else                            err_addr   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: a DDRAM-level model is checked every quiet
// cycle, plus hand-computed literal expectations at each step.
module tb_lcd_bus_monitor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         LCD_E = 1'b0;
  logic         LCD_RS = 1'b0;
  logic         LCD_RW = 1'b0;
  logic [3:0]   LCD_D = 4'h0;
  logic [127:0] row0;
  logic [127:0] row1;
  logic [6:0]   ddram_addr;
  logic         display_on;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_rs;
  logic         busy;
  logic         err_overrun;
  logic         err_read;
  logic         err_addr;

  lcd_bus_monitor #(.CLEAR_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_D(LCD_D), .row0(row0), .row1(row1), .ddram_addr(ddram_addr),
    .display_on(display_on), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_rs(byte_rs), .busy(busy), .err_overrun(err_overrun),
    .err_read(err_read), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the whole 128-byte DDRAM address space; the display shows 0x00-0x0F and 0x40-0x4F
  logic [7:0] m_ram [0:127];
  int         m_addr;
  int         m_mode;
  int         m_hi;
  logic       m_disp;
  logic [7:0] m_bdata;
  logic       m_brs;
  logic       m_err_ov;
  logic       m_err_rd;
  logic       m_err_ad;
  int         m_bytes = 0;
  logic       clear_active = 1'b0;
  logic       check_en = 1'b0;

  int bv_count = 0;
  int busy_run = 0;
  int busy_len = 0;

  function automatic logic [127:0] model_row(input int base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m_ram[base+i];
    return r;
  endfunction

  function automatic bit shown(input int a);
    return (a >= 'h00 && a <= 'h0F) || (a >= 'h40 && a <= 'h4F);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
    m_addr = 0; m_mode = 0; m_hi = 0; m_disp = 1'b0;
    m_bdata = 8'h00; m_brs = 1'b0;
    m_err_ov = 1'b0; m_err_rd = 1'b0; m_err_ad = 1'b0;
    clear_active = 1'b0;
  endtask

  task automatic model_nibble(input logic rs, input logic rw, input int d);
    int b;
    if (rw) begin m_err_rd = 1'b1; return; end
    if (clear_active) begin m_err_ov = 1'b1; return; end
    if (m_mode == 0) begin
      if (d == 2) m_mode = 1;
    end else if (m_mode == 1) begin
      m_hi = d; m_mode = 2;
    end else begin
      b = m_hi * 16 + d;
      m_mode = 1;
      m_bytes++;
      m_bdata = 8'(b);
      m_brs = rs;
      if (rs) begin
        m_ram[m_addr] = 8'(b);
        if (m_addr == 'h0F)      m_addr = 'h40;
        else if (m_addr == 'h4F) m_addr = 'h00;
        else                     m_addr = (m_addr + 1) % 128;
      end else if (b == 1) begin
        for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
        m_addr = 0;
        clear_active = 1'b1;
      end else if (b == 2 || b == 3) begin
        m_addr = 0;
      end else if (b >= 8 && b <= 15) begin
        m_disp = (b / 4) % 2 == 1;
      end else if (b >= 128) begin
        if (shown(b - 128)) m_addr = b - 128;
        else m_err_ad = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One nibble transfer: E high 3 cycles, low with data held 5 cycles, then update the model
  task automatic applyStimulus(input logic rs, input logic rw, input logic [3:0] d);
    check_en = 1'b0;
    @(posedge clk); #1;
    LCD_RS = rs; LCD_RW = rw; LCD_D = d; LCD_E = 1'b1;
    repeat (3) @(posedge clk);
    #1 LCD_E = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_nibble(rs, rw, int'(d));
    check_en = 1'b1;
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b);
    applyStimulus(rs, 1'b0, b[7:4]);
    applyStimulus(rs, 1'b0, b[3:0]);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (byte_valid) bv_count++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin busy_len = busy_run; busy_run = 0; end
      if (check_en && !clear_active && !rst) begin
        checkOutput("row0", row0, model_row('h00));
        checkOutput("row1", row1, model_row('h40));
        checkOutput("ddram_addr", 128'(ddram_addr), 128'(m_addr));
        checkOutput("display_on", 128'(display_on), 128'(m_disp));
        checkOutput("byte_valid", 128'(byte_valid), 128'(0));
        checkOutput("byte_data", 128'(byte_data), 128'(m_bdata));
        checkOutput("byte_rs", 128'(byte_rs), 128'(m_brs));
        checkOutput("busy", 128'(busy), 128'(0));
        checkOutput("err_overrun", 128'(err_overrun), 128'(m_err_ov));
        checkOutput("err_read", 128'(err_read), 128'(m_err_rd));
        checkOutput("err_addr", 128'(err_addr), 128'(m_err_ad));
      end
    end
  endtask

  initial begin
    int n;
    model_reset();
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    checkOutput("reset_row0", row0, {16{8'h20}});
    checkOutput("reset_row1", row1, {16{8'h20}});
    checkOutput("reset_addr", 128'(ddram_addr), 128'h0);
    checkOutput("reset_flags", 128'({display_on, byte_valid, byte_rs, busy, err_overrun, err_read, err_addr}), 128'h0);
    checkOutput("reset_byte_data", 128'(byte_data), 128'h0);

    // Init: three 8-bit-mode nibbles, switch to 4-bit, then function set / display on / entry mode
    applyStimulus(1'b0, 1'b0, 4'h3);
    applyStimulus(1'b0, 1'b0, 4'h3);
    applyStimulus(1'b0, 1'b0, 4'h3);
    applyStimulus(1'b0, 1'b0, 4'h2);
    sendByte(1'b0, 8'h28);
    sendByte(1'b0, 8'h0C);
    sendByte(1'b0, 8'h06);
    checkOutput("init_display_on", 128'(display_on), 128'h1);
    checkOutput("init_errors", 128'({err_overrun, err_read, err_addr}), 128'h0);
    checkOutput("init_byte_count", 128'(bv_count), 128'd3);

    sendByte(1'b1, 8'h41);
    sendByte(1'b1, 8'h42);
    checkOutput("data_row0_AB", 128'(row0[127:112]), 128'h4142);
    checkOutput("data_addr", 128'(ddram_addr), 128'h02);
    checkOutput("data_byte_rs", 128'(byte_rs), 128'h1);
    checkOutput("data_byte_count", 128'(bv_count), 128'd5);

    sendByte(1'b0, 8'hC0);
    sendByte(1'b1, 8'h5A);
    checkOutput("row1_char0_5A", 128'(row1[127:120]), 128'h5A);
    checkOutput("row1_addr", 128'(ddram_addr), 128'h41);
    sendByte(1'b0, 8'h9F);
    checkOutput("bad_addr_flag", 128'(err_addr), 128'h1);
    checkOutput("bad_addr_kept", 128'(ddram_addr), 128'h41);

    sendByte(1'b0, 8'h8F);
    sendByte(1'b1, 8'h31);
    sendByte(1'b1, 8'h32);
    checkOutput("wrap_row0_ch15", 128'(row0[7:0]), 128'h31);
    checkOutput("wrap_row1_ch0", 128'(row1[127:120]), 128'h32);
    checkOutput("wrap_addr", 128'(ddram_addr), 128'h41);

    applyStimulus(1'b0, 1'b1, 4'h5);
    checkOutput("read_flag", 128'(err_read), 128'h1);
    sendByte(1'b1, 8'h44);
    checkOutput("after_read_row1_ch1", 128'(row1[119:112]), 128'h44);

    sendByte(1'b0, 8'hCF);
    sendByte(1'b1, 8'h33);
    checkOutput("wrap4f_row1_ch15", 128'(row1[7:0]), 128'h33);
    checkOutput("wrap4f_addr", 128'(ddram_addr), 128'h00);

    sendByte(1'b0, 8'h08);
    checkOutput("display_off", 128'(display_on), 128'h0);
    sendByte(1'b0, 8'h85);
    sendByte(1'b0, 8'h02);
    checkOutput("home_addr", 128'(ddram_addr), 128'h00);

    // Clear, with a second strobe landing while the fill is still running
    sendByte(1'b0, 8'h01);
    applyStimulus(1'b1, 1'b0, 4'h7);
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) begin
      errors++;
      $display("[TB] FAIL busy_timeout: busy still %b after %0d cycles, expected 0", busy, n);
    end
    repeat (2) @(posedge clk);
    #1 clear_active = 1'b0;
    checkOutput("clear_busy_len", 128'(busy_len), 128'd32);
    checkOutput("clear_overrun", 128'(err_overrun), 128'h1);
    checkOutput("clear_row0", row0, {16{8'h20}});
    checkOutput("clear_row1", row1, {16{8'h20}});
    checkOutput("clear_addr", 128'(ddram_addr), 128'h00);
    sendByte(1'b1, 8'h48);
    checkOutput("after_clear_row0_ch0", 128'(row0[127:120]), 128'h48);

    // Reset in the middle of a data byte
    sendByte(1'b1, 8'h4B);
    applyStimulus(1'b1, 1'b0, 4'h4);
    check_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    checkOutput("midrst_row0", row0, {16{8'h20}});
    checkOutput("midrst_flags", 128'({display_on, busy, err_overrun, err_read, err_addr}), 128'h0);
    checkOutput("midrst_addr", 128'(ddram_addr), 128'h00);
    applyStimulus(1'b1, 1'b0, 4'h4);
    applyStimulus(1'b0, 1'b0, 4'h2);
    sendByte(1'b1, 8'h41);
    checkOutput("midrst_row0_ch0", 128'(row0[127:120]), 128'h41);
    checkOutput("midrst_addr_after", 128'(ddram_addr), 128'h01);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("byte_count_total", 128'(bv_count), 128'(m_bytes));
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
# lcd_bus_monitor

Receiving end of the 4-bit HD44780-style character-LCD write bus that `main` drives. It samples LCD_E/LCD_RS/LCD_RW/LCD_D and reassembles nibbles into instruction and data bytes. It executes the instruction subset our LCD driver uses and keeps a 2×16 shadow of display RAM. Both rows are exported as flat buses so benches and on-board checkers can compare displayed text without decoding waveforms.

## Interface
Parameters:
- `CLEAR_CYCLES`, default 32: clock cycles the clear-display fill occupies (one RAM cell per cycle).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `LCD_E`  in  1  enable strobe from the LCD driver (asynchronous to `clk`).
- `LCD_RS`  in  1  0 = instruction, 1 = data.
- `LCD_RW`  in  1  0 = write; 1 = read (unsupported).
- `LCD_D`  in  4  nibble bus.
- `row0`  out  128  line 1; char 0 in bits [127:120].
- `row1`  out  128  line 2; same packing.
- `ddram_addr`  out  7  current cursor address.
- `display_on`  out  1  D bit of the last display-control instruction.
- `byte_valid`  out  1  one-cycle pulse when a full byte completes.
- `byte_data`  out  8  last completed byte.
- `byte_rs`  out  1  RS of the last completed byte.
- `busy`  out  1  high while a clear fill is in progress.
- `err_overrun`  out  1  sticky: E strobe arrived while `busy`.
- `err_read`  out  1  sticky: E strobe arrived with RW=1.
- `err_addr`  out  1  sticky: set-DDRAM address outside 0x00–0x0F / 0x40–0x4F.

## Operation
- LCD_E, LCD_RS, LCD_RW and LCD_D each pass through a 2-flop synchronizer.
- A strobe is a synchronized falling edge of E. RS, RW and D are taken from the synchronized copies on that same cycle.
- Strobe with RW=1: set `err_read` and discard the nibble. Strobe while `busy`: set `err_overrun` and discard the nibble.
- FSM states:
  - INIT: each strobe is a standalone 8-bit-mode nibble. 0x3 stays in INIT; 0x2 moves to HI; other values are ignored.
  - HI: latch the nibble as the upper half and go to LO.
  - LO: combine with the latched upper half, pulse `byte_valid`, execute the byte, then return to HI, or go to CLR if the byte is a clear.
  - CLR: write 0x20 to one cell per cycle, 32 cells in order (row0 char 0 first). Set `ddram_addr`=0x00 and return to HI.
- Instruction execution (RS=0):
  - 0x01: clear display (enter CLR).
  - 0x02/0x03: `ddram_addr`=0x00.
  - 0x08–0x0F: `display_on`=bit2.
  - 0x80|a: `ddram_addr`=a if a is valid; otherwise set `err_addr` and leave the address unchanged.
  - 0x20–0x3F and 0x04–0x07: accepted, no effect.
- Data execution (RS=1): write the byte at `ddram_addr`, then increment the address.
  - Wrap 0x0F→0x40 and 0x4F→0x00.
  - If `ddram_addr` is invalid, the write is dropped and only the increment applies. Address stays 7 bits.
- Reset values:
  - FSM = INIT.
  - `row0`/`row1` all 0x20.
  - `ddram_addr`, `display_on`, `byte_valid`, `byte_data`, `byte_rs`, `busy` and all error flags = 0.
- A reset mid-operation (mid-byte or mid-clear) abandons it and restores the reset values on the next edge.

## Timing
- E falling at the pins is detected 3 `clk` edges later (2 synchronizer edges plus 1 edge-detect register). The driver must hold RS/RW/D stable for at least 3 cycles after E falls.
- Minimum E high and low widths: 2 cycles each. Shorter pulses may be missed.
- `byte_valid`, `byte_data`, `byte_rs` and the RAM/address/flag updates all register on the cycle after the LO strobe is detected.
- `busy` rises on that same cycle and stays high for exactly `CLEAR_CYCLES` cycles. The next strobe is accepted on the cycle `busy` falls.
- `row0`/`row1` are registered outputs; each write is visible one cycle after it executes.
- If a strobe and the last CLR cycle coincide, the strobe counts as overrun.

## Test plan
- Init sequence: nibbles 3,3,3,2 then bytes 0x28, 0x0C, 0x06 → FSM in HI; `display_on`=1; no error flags; row0/row1 all 0x20.
- After init, data 0x41 then 0x42 → `row0`[127:112]=0x4142; `ddram_addr`=0x02; two `byte_valid` pulses with `byte_rs`=1.
- Instruction 0xC0 then data 0x5A → `row1`[127:120]=0x5A, `ddram_addr`=0x41. Instruction 0x9F → `err_addr`=1, `ddram_addr` still 0x41.
- Address 0x8F then data 0x31, 0x32 → row0 char 15 = 0x31, row1 char 0 = 0x32, `ddram_addr`=0x41.
- Instruction 0x01 with a strobe issued 5 cycles later → `busy` high for 32 cycles; `err_overrun`=1; all cells 0x20; `ddram_addr`=0x00.
- Assert `rst` after only the upper nibble of a data byte → all outputs at reset values; FSM back in INIT (a following strobe with nibble 0x4 is treated as an init nibble, not as a lower half).
